// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
//
// Purpose:
//   Registered, handshaked ALU control decode. An opcode field from the
//   decode stage is turned into an ALU control code and held on the output
//   until the ALU consumes it. Codes flagged in MC_MASK are multi-cycle: they
//   are held for MC_CYCLES extra cycles (busy_o high) before being presented.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   opcode on in_op_i is valid
//   in_ready_o   block can accept an opcode this cycle (no in_valid_i path)
//   in_op_i      instruction opcode field, top 2 bits are the class
//   out_valid_o  alu_cnt_o is valid for the ALU
//   out_ready_i  ALU consumes alu_cnt_o this cycle
//   alu_cnt_o    ALU control code (registered)
//   illegal_o    alu_cnt_o came from an illegal opcode, qualified by out_valid_o
//   busy_o       multi-cycle hold in progress
// ---------------------------------------------------------------------------
module alu_control_seq #(
  parameter int unsigned                 OP_W        = 6,
  parameter int unsigned                 CNT_W       = 4,
  parameter logic [(1 << CNT_W)-1:0]     MC_MASK     = 16'h0F00,
  parameter int unsigned                 MC_CYCLES   = 3,
  parameter logic [CNT_W-1:0]            DEFAULT_CNT = 4'b0111
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OP_W-1:0]  in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] alu_cnt_o,
  output logic             illegal_o,
  output logic             busy_o
);

  localparam int unsigned IDX_W = OP_W - 2;

  // A zero-cycle configuration never enters HOLD, but the counter still
  // needs at least one bit to stay a legal vector.
  localparam int unsigned HC_W = (MC_CYCLES > 0) ? $clog2(MC_CYCLES + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD =
    HC_W'((MC_CYCLES > 0) ? (MC_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    VALID
  } state_e;

  state_e            state_q, state_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d;
  logic              illegal_q, illegal_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [1:0]        op_class;
  logic [IDX_W-1:0]  op_idx;
  logic [31:0]       idx_ext;
  logic [CNT_W-1:0]  dec_code;
  logic              dec_illegal;
  logic              dec_multi;
  logic              in_ready;
  logic              accept;

  assign op_class = in_op_i[OP_W-1:OP_W-2];
  assign op_idx   = in_op_i[OP_W-3:0];
  // Widening to 32 bits lets one comparison cover both index fields that are
  // narrower and wider than the code width.
  assign idx_ext  = 32'(op_idx);

  // Opcode decode. Load/store/branch all use add (code 0). In the ALU class
  // the index is the code itself, except that index 5 aliases to code 1 for
  // compatibility with the old decoder; indices that do not fit in a code are
  // replaced by DEFAULT_CNT and flagged illegal.
  always_comb begin
    dec_code    = '0;
    dec_illegal = 1'b0;
    if (op_class == 2'b11) begin
      if (idx_ext >= (32'd1 << CNT_W)) begin
        dec_code    = DEFAULT_CNT;
        dec_illegal = 1'b1;
      end else if (idx_ext == 32'd5) begin
        dec_code = CNT_W'(1);
      end else begin
        dec_code = idx_ext[CNT_W-1:0];
      end
    end
  end

  assign dec_multi = (MC_CYCLES != 0) && MC_MASK[dec_code];

  // Ready depends only on state and the downstream ready, so the upstream
  // sequencer can base its valid on it without a combinational loop. A
  // VALID entry can be replaced in the same cycle it is consumed.
  always_comb begin
    in_ready = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        VALID:   in_ready = out_ready_i;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept     = in_valid_i && in_ready;
  assign in_ready_o = in_ready;

  // Next-state logic. A capture loads the decoded code and chooses between
  // presenting it at once or holding it for the multi-cycle count. The
  // output flags are computed from the next state so they can be registered.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    alu_cnt_d  = alu_cnt_q;
    illegal_d  = illegal_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_cnt_d = dec_code;
          illegal_d = dec_illegal;
          if (dec_multi) begin
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
          end else begin
            state_d = VALID;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = VALID;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      VALID: begin
        if (out_ready_i) begin
          if (accept) begin
            alu_cnt_d = dec_code;
            illegal_d = dec_illegal;
            if (dec_multi) begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_LOAD;
            end else begin
              state_d = VALID;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == VALID);
    busy_d      = (state_d == HOLD);
  end

  // State and output registers. Reset abandons any held operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      alu_cnt_q   <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      alu_cnt_q   <= alu_cnt_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign alu_cnt_o   = alu_cnt_q;
  assign illegal_o   = illegal_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_control_seq
//
// Self-checking bench for alu_control_seq. Directed scenarios cover reset,
// class decode, streaming, multi-cycle hold, backpressure, illegal opcodes
// (on a 7-bit opcode instance) and reset during an operation; a randomized
// phase compares against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_alu_control_seq;

  localparam int OP_W      = 6;
  localparam int CNT_W     = 4;
  localparam int MC_CYCLES = 3;
  localparam int MC_MASK   = 16'h0F00;
  localparam int DEF_CNT   = 7;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] alu_cnt;
  logic             illegal;
  logic             busy;

  logic             in_valid7;
  logic             in_ready7;
  logic [6:0]       in_op7;
  logic             out_valid7;
  logic             out_ready7;
  logic [3:0]       alu_cnt7;
  logic             illegal7;
  logic             busy7;

  int tests_run;
  int tests_failed;

  alu_control_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .alu_cnt_o   (alu_cnt),
    .illegal_o   (illegal),
    .busy_o      (busy)
  );

  alu_control_seq #(.OP_W(7)) dut7 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid7),
    .in_ready_o  (in_ready7),
    .in_op_i     (in_op7),
    .out_valid_o (out_valid7),
    .out_ready_i (out_ready7),
    .alu_cnt_o   (alu_cnt7),
    .illegal_o   (illegal7),
    .busy_o      (busy7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode, straight from the opcode rules.
  function automatic void ref_decode(input int op, input int op_w,
                                     output int code, output bit ill,
                                     output bit mc);
    int cls;
    int idx;
    cls  = op >> (op_w - 2);
    idx  = op % (1 << (op_w - 2));
    code = 0;
    ill  = 1'b0;
    if (cls == 3) begin
      if (idx >= (1 << CNT_W)) begin
        code = DEF_CNT;
        ill  = 1'b1;
      end else if (idx == 5) begin
        code = 1;
      end else begin
        code = idx;
      end
    end
    mc = (MC_CYCLES > 0) && (((MC_MASK >> code) & 1) == 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_op = '0; out_ready = 1'b1;
    in_valid7 = 1'b0; in_op7 = '0; out_ready7 = 1'b1;
    tick(); tick();
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%b b=%b c=%0d i=%b, expected all 0",
               out_valid, busy, alu_cnt, illegal);
    end
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready_low: got %b, expected 0", in_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready_high: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_classes();
    logic [5:0] ops [3];
    ops[0] = 6'b000011; ops[1] = 6'b010000; ops[2] = 6'b101111;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = ops[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || alu_cnt !== 4'd0 || illegal !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL class_decode[%0d]: got v=%b c=%0d i=%b, expected v=1 c=0 i=0",
                 i, out_valid, alu_cnt, illegal);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL class_consume[%0d]: got v=%b, expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_stream();
    int exp_codes [8];
    exp_codes = '{0, 1, 2, 3, 4, 1, 6, 7};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op = {2'b11, 4'(i)}; in_valid = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stream_ready[%0d]: got %b, expected 1", i, in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || alu_cnt !== 4'(exp_codes[i])) begin
        tests_failed++;
        $display("[TB] FAIL stream_code[%0d]: got v=%b c=%0d, expected v=1 c=%0d",
                 i, out_valid, alu_cnt, exp_codes[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drain: got v=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_multicycle();
    out_ready = 1'b1;
    in_op = 6'b111001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < MC_CYCLES; c++) begin
      tests_run++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mc_hold[%0d]: got b=%b v=%b r=%b, expected b=1 v=0 r=0",
                 c, busy, out_valid, in_ready);
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || alu_cnt !== 4'd9) begin
      tests_failed++;
      $display("[TB] FAIL mc_present: got v=%b b=%b c=%0d, expected v=1 b=0 c=9",
               out_valid, busy, alu_cnt);
    end
    in_op = 6'b110010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || alu_cnt !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL mc_followup: got v=%b c=%0d, expected v=1 c=2", out_valid, alu_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back_backpressure();
    out_ready = 1'b0;
    in_op = 6'b111100; in_valid = 1'b1;
    tick();
    in_op = 6'b110011;
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (out_valid !== 1'b1 || alu_cnt !== 4'd12 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bp_stall[%0d]: got v=%b c=%0d r=%b, expected v=1 c=12 r=0",
                 c, out_valid, alu_cnt, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_release_ready: got %b, expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || alu_cnt !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL bp_back_to_back: got v=%b c=%0d, expected v=1 c=3", out_valid, alu_cnt);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain: got v=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready7 = 1'b1;
    in_op7 = 7'b1110011; in_valid7 = 1'b1;
    #1;
    tests_run++;
    if (in_ready7 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_ready: got %b, expected 1", in_ready7);
    end
    tick();
    in_op7 = 7'b1101100;
    tests_run++;
    if (out_valid7 !== 1'b1 || alu_cnt7 !== 4'b0111 || illegal7 !== 1'b1 || busy7 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL illegal_idx19: got v=%b c=%0d i=%b b=%b, expected v=1 c=7 i=1 b=0",
               out_valid7, alu_cnt7, illegal7, busy7);
    end
    tick();
    in_valid7 = 1'b0;
    tests_run++;
    if (out_valid7 !== 1'b1 || alu_cnt7 !== 4'd12 || illegal7 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL legal_idx12_w7: got v=%b c=%0d i=%b, expected v=1 c=12 i=0",
               out_valid7, alu_cnt7, illegal7);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b1;
    in_op = 6'b111010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || alu_cnt !== 4'd0 || illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_midhold: got v=%b b=%b c=%0d i=%b, expected all 0",
               out_valid, busy, alu_cnt, illegal);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rst_no_pulse[%0d]: got v=%b b=%b, expected 0 0", c, out_valid, busy);
      end
    end
    out_ready = 1'b0;
    in_op = 6'b110100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || alu_cnt !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_midvalid: got v=%b c=%0d, expected v=0 c=0", out_valid, alu_cnt);
    end
  endtask

  // Transaction-level model: one slot that is either empty or holds a code
  // with a number of busy cycles still to run.
  task automatic test_random();
    bit held;
    int wait_left;
    int code;
    bit ill;
    bit mc;
    bit exp_ready;
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    held = 1'b0; wait_left = 0; code = 0; ill = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = ($urandom_range(0, 1) == 1) ? {2'b11, 4'($urandom)} : 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = !held || (wait_left == 0 && out_ready);
      tests_run++;
      if (in_ready !== exp_ready) begin
        tests_failed++;
        $display("[TB] FAIL rand_ready[%0d]: got %b, expected %b", cyc, in_ready, exp_ready);
      end
      @(posedge clk);
      if (held && wait_left > 0) wait_left--;
      else if (held && out_ready) held = 1'b0;
      if (in_valid && exp_ready) begin
        ref_decode(int'(in_op), OP_W, code, ill, mc);
        held = 1'b1;
        wait_left = mc ? MC_CYCLES : 0;
      end
      #1;
      tests_run++;
      if (out_valid !== (held && wait_left == 0) || busy !== (held && wait_left > 0)) begin
        tests_failed++;
        $display("[TB] FAIL rand_flags[%0d]: got v=%b b=%b, expected v=%b b=%b", cyc,
                 out_valid, busy, held && wait_left == 0, held && wait_left > 0);
      end
      if (held) begin
        tests_run++;
        if (alu_cnt !== 4'(code) || (wait_left == 0 && illegal !== ill)) begin
          tests_failed++;
          $display("[TB] FAIL rand_code[%0d]: got c=%0d i=%b, expected c=%0d i=%b",
                   cyc, alu_cnt, illegal, code, ill);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_classes();
    test_stream();
    test_multicycle();
    test_back_to_back_backpressure();
    test_illegal();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parametrised, handshaked successor to the combinational ALU control decode. It accepts the instruction opcode field from the decode stage and produces a registered ALU control code. Codes marked as multi-cycle (shift/rotate class by default) are held for a programmable number of extra cycles before being presented. The block sits between instruction decode and the ALU, and its valid/ready handshakes let the sequencer stall on multi-cycle ALU operations.

## Interface
- OP_W, 6: opcode field width; top 2 bits are the instruction class; must be ≥ 3.
- CNT_W, 4: ALU control code width; must be ≥ 1.
- MC_MASK, 16'h0F00: bit k set means ALU code k is multi-cycle; width 2^CNT_W.
- MC_CYCLES, 3: extra hold cycles for a multi-cycle code; 0 makes every code single-cycle.
- DEFAULT_CNT, 4'b0111: code emitted for an illegal opcode.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  opcode on in_op is valid
- in_ready  out  1  block can accept an opcode this cycle
- in_op  in  OP_W  instruction opcode field (top OP_W bits of the instruction)
- out_valid  out  1  alu_cnt is valid for the ALU
- out_ready  in  1  ALU consumes alu_cnt this cycle
- alu_cnt  out  CNT_W  ALU control code
- illegal  out  1  the code held in alu_cnt came from an illegal opcode; qualified by out_valid
- busy  out  1  multi-cycle hold in progress

## Operation
- Decode runs combinationally on in_op. The result is captured only on an accept, i.e. when in_valid && in_ready.
- Class = in_op[OP_W-1:OP_W-2].
  - Classes 00 (load), 01 (store) and 10 (branch) decode to 0 (add).
  - Class 11: idx = in_op[OP_W-3:0].
    - idx == 5 decodes to 1. This alias is kept for compatibility.
    - Otherwise idx decodes to idx, zero-extended to CNT_W.
    - If idx ≥ 2^CNT_W, the code is DEFAULT_CNT and illegal is set.
- Multi-cycle: the decoded code k is multi-cycle when MC_MASK[k] == 1 and MC_CYCLES > 0.
- FSM states:
  - IDLE: nothing held. in_ready = 1.
    - Accept of a single-cycle code → VALID.
    - Accept of a multi-cycle code → HOLD, with the counter loaded to MC_CYCLES-1.
  - HOLD: busy = 1, out_valid = 0, in_ready = 0. alu_cnt already shows the captured code. The counter decrements each cycle; at 0 → VALID.
  - VALID: out_valid = 1. alu_cnt and illegal are stable until consumed.
    - out_ready = 0: stay in VALID.
    - out_ready = 1 and no new accept → IDLE.
    - in_ready = out_ready. An accept in the same cycle as consumption captures the new code and goes to VALID or HOLD, giving back-to-back throughput of 1 per cycle.
- in_op changes while in_valid = 0 have no effect.
- The counter width is clog2(MC_CYCLES+1), and the counter never wraps.

## Timing
- Reset values:
  - State: IDLE.
  - alu_cnt: 0. illegal: 0. busy: 0. out_valid: 0. Counter: 0.
  - in_ready: 0 while rst = 1, 1 in the first cycle after rst is released.
- Reset asserted mid-HOLD or mid-VALID abandons the operation. Outputs take their reset values on the next edge, and no out_valid pulse follows.
- Single-cycle latency: accept at edge T → out_valid = 1 after edge T.
- Multi-cycle latency: accept at edge T → busy = 1 for MC_CYCLES cycles → out_valid = 1 after edge T+MC_CYCLES.
- The output is registered: alu_cnt, illegal, busy and out_valid come straight from flops.
- in_ready is combinational from the state and out_ready only. It has no dependency on in_valid.
- Sustained throughput:
  - Single-cycle codes: 1 per cycle while out_ready = 1.
  - Multi-cycle codes: 1 per MC_CYCLES+1 cycles.
- Backpressure: when out_ready = 0 in VALID, nothing is accepted and no output changes.

## Test plan
- Reset, then in_op = 6'b000011, in_valid = 1 for one cycle, out_ready = 1 → out_valid = 1 the next cycle with alu_cnt = 0 and illegal = 0. Repeat with 6'b010000 and 6'b101111: both give alu_cnt = 0.
- Stream 6'b110000 to 6'b110111 on consecutive cycles with out_ready = 1 → alu_cnt sequence 0,1,2,3,4,1,6,7, one per cycle with no bubbles.
- Send in_op = 6'b111001 (code 9, multi-cycle) → busy = 1 for 3 cycles, in_ready = 0 for those cycles, then out_valid = 1 with alu_cnt = 9. A following 6'b110010 then yields alu_cnt = 2 one cycle after its accept.
- Send in_op = 6'b111100 with out_ready = 0 for 4 cycles → out_valid stays 1 with alu_cnt = 12 and in_ready = 0 for 4 cycles. Raising out_ready consumes it, and in_ready rises in the same cycle.
- With OP_W = 7 and CNT_W = 4, send in_op = 7'b1110011 (idx 19) → alu_cnt = 4'b0111, illegal = 1.
- Assert rst during the second busy cycle of code 10 → the next cycle shows out_valid = 0, busy = 0, alu_cnt = 0, and no out_valid occurs until a new accept.
